sha256_msg_schedule: RTL and testbench

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_w_expand.sv | 32 +++
 rtl/sha256_msg_schedule.sv | 99 +++++++++
 tb/tb_sha256_msg_schedule.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 round constants, message-schedule helpers and FSM state type
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Message words arrive in little-endian memory order; SHA-256 works big-endian.
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// rtl/sha256_w_expand.sv - 16-word message window with next-word expansion on shift
import sha256_pkg::*;

module sha256_w_expand (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [3:0]  load_idx,
  input  logic [31:0] load_data,
  input  logic        shift,
  output logic [31:0] w_head
);

  logic [31:0] win [16];
  logic [31:0] w_next;

  // win[0] is W[t]; win[15] receives W[t+16] built from the words it depends on.
  assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  assign w_head = win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_next;
    end else if (load) begin
      win[load_idx] <= load_data;
    end
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 chunk loader, round sequencer and W/K feed for the compressor
import sha256_pkg::*;

module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic        enable,
  output logic        update,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t     state;
  logic [3:0] wcnt;
  logic [5:0] t;
  logic       last_q;
  logic       accept;

  // s_ready is registered but always equals (state == ST_LOAD).
  assign accept = s_valid && s_ready;

  sha256_w_expand u_w_expand (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_idx  (wcnt),
    .load_data (bswap(s_data)),
    .shift     (state == ST_ROUND),
    .w_head    (w_out)
  );

  assign k_out = K_TABLE[t];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LOAD;
      wcnt    <= '0;
      t       <= '0;
      last_q  <= 1'b0;
      s_ready <= 1'b1;
      enable  <= 1'b0;
      update  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd15) begin
              last_q  <= s_last;
              wcnt    <= '0;
              t       <= '0;
              state   <= ST_ROUND;
              s_ready <= 1'b0;
              enable  <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        ST_ROUND: begin
          if (t == LAST_ROUND) begin
            state  <= ST_UPDATE;
            update <= 1'b1;
          end else begin
            t <= t + 6'd1;
          end
        end
        ST_UPDATE: begin
          state   <= ST_LOAD;
          s_ready <= 1'b1;
          enable  <= 1'b0;
          update  <= 1'b0;
          busy    <= 1'b0;
          done    <= last_q;
        end
        default: begin
          state   <= ST_LOAD;
          s_ready <= 1'b1;
          enable  <= 1'b0;
          update  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed vector bench for the SHA-256 message schedule
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [31:0] w_out;
  logic [31:0] k_out;
  logic        enable;
  logic        update;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];

  typedef struct {
    int          round;
    logic        chk_w;
    logic [31:0] exp_w;
    logic [31:0] exp_k;
  } vec_t;

  vec_t vecs [6];

  sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .w_out   (w_out),
    .k_out   (k_out),
    .enable  (enable),
    .update  (update),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] m_bs(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Textbook recurrence over the full W array, independent of the window form.
  task automatic build_model();
    for (int i = 0; i < 16; i++) exp_w[i] = m_bs(msg[i]);
    for (int i = 16; i < 64; i++)
      exp_w[i] = m_s1(exp_w[i-2]) + exp_w[i-7] + m_s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h80636261;
    msg[15] = 32'h18000000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered on a negedge in LOAD; returns on the negedge of round 0.
  task automatic load_chunk(input logic last, input logic gaps, input logic hold_valid);
    for (int i = 0; i < 16; i++) begin
      if (gaps && i > 0) begin
        s_valid = 1'b0;
        s_data  = 32'hdeadbeef;
        @(negedge clk);
      end
      check("s_ready_load", {31'b0, s_ready}, 32'd1);
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = (i == 15) ? last : ~last;
      @(negedge clk);
    end
    s_last = 1'b0;
    if (hold_valid) s_data = 32'hffffffff;
    else s_valid = 1'b0;
  endtask

  // Checks each round; stop_at < 64 pulses rst on that round and returns.
  task automatic run_rounds(input logic exp_done, input int stop_at);
    for (int t = 0; t < 64; t++) begin
      if (t == stop_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        check("rst_mid_ready",  {31'b0, s_ready}, 32'd1);
        check("rst_mid_enable", {31'b0, enable},  32'd0);
        check("rst_mid_busy",   {31'b0, busy},    32'd0);
        return;
      end
      cap_w[t] = w_out;
      cap_k[t] = k_out;
      n_vec++;
      if (!(enable === 1'b1 && busy === 1'b1 && update === 1'b0 && s_ready === 1'b0 &&
            w_out === exp_w[t] && k_out === kt[t])) begin
        n_bad++;
        $display("FAIL round_%0d: got w=%h k=%h en=%b up=%b busy=%b rdy=%b, expected w=%h k=%h en=1 up=0 busy=1 rdy=0",
                 t, w_out, k_out, enable, update, busy, s_ready, exp_w[t], kt[t]);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("upd_update", {31'b0, update},  32'd1);
    check("upd_enable", {31'b0, enable},  32'd1);
    check("upd_busy",   {28'b0, busy, s_ready, done, 1'b0}, 32'b1000);
    @(negedge clk);
    check("post_ready",  {31'b0, s_ready}, 32'd1);
    check("post_enable", {30'b0, enable, update}, 32'd0);
    check("post_busy",   {31'b0, busy},    32'd0);
    check("post_done",   {31'b0, done},    {31'b0, exp_done});
    @(negedge clk);
    check("done_pulse",  {31'b0, done},    32'd0);
  endtask

  initial begin
    vecs[0] = '{0,  1'b1, 32'h61626380, 32'h428a2f98};
    vecs[1] = '{1,  1'b1, 32'h00000000, 32'h71374491};
    vecs[2] = '{15, 1'b1, 32'h00000018, 32'hc19bf174};
    vecs[3] = '{16, 1'b1, 32'h61626380, 32'he49b69c1};
    vecs[4] = '{17, 1'b1, 32'h000f0000, 32'hefbe4786};
    vecs[5] = '{63, 1'b0, 32'h00000000, 32'hc67178f2};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 32'h0;
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready",  {31'b0, s_ready}, 32'd1);
    check("rst_enable", {31'b0, enable},  32'd0);
    check("rst_update", {31'b0, update},  32'd0);
    check("rst_busy",   {31'b0, busy},    32'd0);
    check("rst_done",   {31'b0, done},    32'd0);
    check("rst_w",      w_out,            32'h0);
    check("rst_k",      k_out,            32'h428a2f98);

    // "abc" single chunk, back-to-back words
    set_abc();
    build_model();
    load_chunk(1'b1, 1'b0, 1'b0);
    run_rounds(1'b1, 64);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].chk_w) check($sformatf("abc_w%0d", vecs[i].round), cap_w[vecs[i].round], vecs[i].exp_w);
      check($sformatf("abc_k%0d", vecs[i].round), cap_k[vecs[i].round], vecs[i].exp_k);
    end

    // gapped s_valid in LOAD, s_valid held high through ROUND/UPDATE
    do_reset();
    load_chunk(1'b1, 1'b1, 1'b1);
    run_rounds(1'b1, 64);

    // reset in the middle of round 30, then a clean chunk
    do_reset();
    load_chunk(1'b1, 1'b0, 1'b0);
    run_rounds(1'b1, 30);
    @(negedge clk);
    load_chunk(1'b1, 1'b0, 1'b0);
    run_rounds(1'b1, 64);

    // two-chunk message with arbitrary data: done only after the second chunk
    do_reset();
    for (int i = 0; i < 16; i++) msg[i] = 32'h01234567 ^ (32'h9e3779b9 * (i + 1));
    build_model();
    load_chunk(1'b0, 1'b0, 1'b0);
    run_rounds(1'b0, 64);
    for (int i = 0; i < 16; i++) msg[i] = 32'hcafef00d + (32'h10204081 * i);
    build_model();
    load_chunk(1'b1, 1'b1, 1'b0);
    run_rounds(1'b1, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
